// File: rtl/sensor_link_pkg.sv
// Shared definitions for the sensor link: transmitter state encoding and UART framing constants.
package sensor_link_pkg;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t IDLE  = 3'd0;
    localparam tx_state_t START = 3'd1;
    localparam tx_state_t DATA  = 3'd2;
    localparam tx_state_t STOP  = 3'd3;
    localparam tx_state_t NEXT  = 3'd4;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART 8N1 shifter: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT clocks.
module uart_tx_byte
    import sensor_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);
    assign tx       = tx_q;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        byte_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    shift_d = data;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = START_BIT;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = STOP_BIT;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                // byte_done fires in the last stop-bit cycle so the frame sequencer can react on the same edge
                if (baud_end) begin
                    baud_d    = '0;
                    state_d   = IDLE;
                    byte_done = 1'b1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = STOP_BIT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/response_transmitter.sv
// Frames a latched response (command, value[, checksum]) onto a UART line on each data_ready rising edge.
// Define RESPONSE_CHECKSUM_EN to append a third byte, command XOR value.
module response_transmitter
    import sensor_link_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data_ready,
    input  logic [7:0] response_command,
    input  logic [7:0] response_value,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

`ifdef RESPONSE_CHECKSUM_EN
    localparam logic [1:0] LAST_BYTE = 2'd2;
`else
    localparam logic [1:0] LAST_BYTE = 2'd1;
`endif

    logic       dr_q;
    logic       trigger;
    tx_state_t  state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] val_q, val_d;
    logic [1:0] idx_q, idx_d;
    logic       done_q, done_d;
    logic       ovr_q, ovr_d;
    logic       byte_start;
    logic [7:0] byte_sel;
    logic [7:0] byte_data;
    logic       byte_done;

    assign trigger = data_ready & ~dr_q;

    always_comb begin
        case (idx_q)
            2'd0:    byte_sel = cmd_q;
            2'd1:    byte_sel = val_q;
`ifdef RESPONSE_CHECKSUM_EN
            2'd2:    byte_sel = cmd_q ^ val_q;
`endif
            default: byte_sel = cmd_q;
        endcase
    end

    // The first byte launches in the trigger cycle, before the latch is visible, so it comes from the port.
    assign byte_data = (state_q == IDLE) ? response_command : byte_sel;

    // Frame level: START stands for "a byte is in flight"; the shifter walks START/DATA/STOP itself.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        val_d      = val_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        ovr_d      = ovr_q;
        byte_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d    = START;
                    cmd_d      = response_command;
                    val_d      = response_value;
                    idx_d      = '0;
                    byte_start = 1'b1;
                end
            end
            START: begin
                if (byte_done) begin
                    if (idx_q == LAST_BYTE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = NEXT;
                        idx_d   = idx_q + 2'd1;
                    end
                end
            end
            NEXT: begin
                state_d    = START;
                byte_start = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (trigger && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dr_q    <= 1'b0;
            state_q <= IDLE;
            cmd_q   <= '0;
            val_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dr_q    <= data_ready;
            state_q <= state_d;
            cmd_q   <= cmd_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clock    (clock),
        .reset    (reset),
        .start    (byte_start),
        .data     (byte_data),
        .tx       (tx),
        .byte_done(byte_done)
    );

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_response_transmitter.sv
// Bench for response_transmitter at 4 clocks per bit: table-driven frames, corner sequences, random traffic.
module tb_response_transmitter;

    localparam int CPB = 4;
`ifdef RESPONSE_CHECKSUM_EN
    localparam int NBYTES = 3;
`else
    localparam int NBYTES = 2;
`endif
    // Each byte is 10 bit times; one idle NEXT cycle separates bytes inside a frame.
    localparam int FRAME_CYC = NBYTES * 10 * CPB + (NBYTES - 1);

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       data_ready = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic [7:0] val = 8'h00;
    logic       tx, busy, done, overrun;

    always #5 clock = ~clock;

    response_transmitter #(
        .CLK_FREQ    (40),
        .BAUD_RATE   (10),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .data_ready      (data_ready),
        .response_command(cmd),
        .response_value  (val),
        .tx              (tx),
        .busy            (busy),
        .done            (done),
        .overrun         (overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of expected tx levels, one per upcoming cycle; empty means idle.
    logic m_q[$];
    logic m_done = 1'b0;
    logic m_ov   = 1'b0;
    logic m_drp  = 1'b0;

    logic       tx_hist[$];
    int         busy_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] dec_bytes[$];
    int         dec_starts[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void push_frame(input logic [7:0] c, input logic [7:0] v);
        logic [7:0] b[3];
        b[0] = c;
        b[1] = v;
        b[2] = c ^ v;
        for (int k = 0; k < NBYTES; k++) begin
            if (k > 0) m_q.push_back(1'b1);
            for (int s = 0; s < 10; s++) begin
                logic lvl;
                lvl = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[k][s-1];
                repeat (CPB) m_q.push_back(lvl);
            end
        end
    endfunction

    function automatic void model_advance(input logic dr, input logic [7:0] c, input logic [7:0] v);
        logic idle;
        idle = (m_q.size() == 0);
        if (!idle) void'(m_q.pop_front());
        m_done = !idle && (m_q.size() == 0);
        if (dr && !m_drp) begin
            if (idle) push_frame(c, v);
            else m_ov = 1'b1;
        end
        m_drp = dr;
    endfunction

    task automatic step(input logic dr, input logic [7:0] c, input logic [7:0] v);
        @(negedge clock);
        check("tx", tx, (m_q.size() != 0) ? 32'(m_q[0]) : 32'd1);
        check("busy", busy, 32'(m_q.size() != 0));
        check("done", done, 32'(m_done));
        check("overrun", overrun, 32'(m_ov));
        tx_hist.push_back(tx);
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        data_ready = dr;
        cmd = c;
        val = v;
        model_advance(dr, c, v);
    endtask

    task automatic do_reset(input logic dr);
        @(negedge clock);
        reset = 1'b0;
        data_ready = dr;
        cmd = 8'h5A;
        val = 8'hC3;
        repeat (2) @(negedge clock);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        m_q.delete();
        m_done = 1'b0;
        m_ov = 1'b0;
        m_drp = 1'b0;
        reset = 1'b1;
        model_advance(data_ready, cmd, val);
    endtask

    function automatic void clear_stats();
        tx_hist.delete();
        busy_cnt = 0;
        done_cnt = 0;
    endfunction

    // Independent UART decoder: find each start bit, sample data bits mid-bit.
    function automatic void decode();
        int i;
        i = 0;
        dec_bytes.delete();
        dec_starts.delete();
        while (i + 10 * CPB <= tx_hist.size()) begin
            if (tx_hist[i] === 1'b0) begin
                logic [7:0] b;
                for (int k = 0; k < 8; k++) b[k] = tx_hist[i + CPB/2 + CPB*(k+1)];
                dec_bytes.push_back(b);
                dec_starts.push_back(i);
                i += 10 * CPB;
            end else begin
                i++;
            end
        end
    endfunction

    task automatic check_frame(input string name, input int base, input logic [7:0] c, input logic [7:0] v);
        check({name, "_cmd"}, (dec_bytes.size() > base) ? 32'(dec_bytes[base]) : 32'hFFFF_FFFF, 32'(c));
        check({name, "_val"}, (dec_bytes.size() > base + 1) ? 32'(dec_bytes[base+1]) : 32'hFFFF_FFFF, 32'(v));
`ifdef RESPONSE_CHECKSUM_EN
        check({name, "_csum"}, (dec_bytes.size() > base + 2) ? 32'(dec_bytes[base+2]) : 32'hFFFF_FFFF, 32'(c ^ v));
`endif
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] val;
        int         hold;
        int         edge2;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{cmd: 8'h01, val: 8'h2A, hold: 1,   edge2: -1, exp_ov: 1'b0};
        vecs[1] = '{cmd: 8'hA5, val: 8'h3C, hold: 200, edge2: -1, exp_ov: 1'b0};
        vecs[2] = '{cmd: 8'hFF, val: 8'h00, hold: 2,   edge2: 10, exp_ov: 1'b1};
        vecs[3] = '{cmd: 8'h00, val: 8'hFF, hold: 5,   edge2: -1, exp_ov: 1'b0};
        vecs[4] = '{cmd: 8'h80, val: 8'h01, hold: 3,   edge2: 40, exp_ov: 1'b1};

        for (int t = 0; t < 5; t++) begin
            int run;
            do_reset(1'b0);
            clear_stats();
            run = 2 + vecs[t].hold + FRAME_CYC + 10;
            for (int c = 0; c < run; c++) begin
                logic dr;
                dr = (c >= 2 && c < 2 + vecs[t].hold) ||
                     (vecs[t].edge2 >= 0 && c >= 2 + vecs[t].edge2 && c < 5 + vecs[t].edge2);
                if (c == 2) step(dr, vecs[t].cmd, vecs[t].val);
                else step(dr, 8'($urandom), 8'($urandom));
            end
            decode();
            check("vec_nbytes", dec_bytes.size(), NBYTES);
            check_frame("vec", 0, vecs[t].cmd, vecs[t].val);
            check("vec_busy_cycles", busy_cnt, FRAME_CYC);
            check("vec_done_pulses", done_cnt, 1);
            check("vec_overrun", overrun, 32'(vecs[t].exp_ov));
`ifdef RESPONSE_CHECKSUM_EN
            if (t == 0) check("vec0_third_byte", (dec_bytes.size() > 2) ? 32'(dec_bytes[2]) : 0, 32'h2B);
`endif
        end

        // Asynchronous reset in the middle of a frame, while tx is low.
        do_reset(1'b0);
        clear_stats();
        step(1'b1, 8'h00, 8'h00);
        for (int c = 0; c < 30; c++) step(1'b0, 8'($urandom), 8'($urandom));
        @(posedge clock);
        #2;
        check("pre_reset_tx_low", tx, 0);
        reset = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        do_reset(1'b0);
        clear_stats();
        step(1'b1, 8'hA7, 8'h4E);
        for (int c = 0; c < FRAME_CYC + 10; c++) step(1'b0, 8'($urandom), 8'($urandom));
        decode();
        check("after_rst_nbytes", dec_bytes.size(), NBYTES);
        check_frame("after_rst", 0, 8'hA7, 8'h4E);

        // data_ready already high when reset releases.
        clear_stats();
        do_reset(1'b1);
        for (int c = 0; c < FRAME_CYC + 10; c++) step(c < 5, 8'($urandom), 8'($urandom));
        decode();
        check("rel_high_nbytes", dec_bytes.size(), NBYTES);
        check_frame("rel_high", 0, 8'h5A, 8'hC3);

        // Trigger landing in the done cycle starts the next frame back to back.
        begin
            int n;
            do_reset(1'b0);
            clear_stats();
            step(1'b1, 8'h12, 8'h34);
            n = 0;
            while (!m_done && n < FRAME_CYC + 10) begin
                step(1'b0, 8'($urandom), 8'($urandom));
                n++;
            end
            step(1'b1, 8'h56, 8'h78);
            for (int c = 0; c < FRAME_CYC + 10; c++) step(1'b0, 8'($urandom), 8'($urandom));
            decode();
            check("b2b_nbytes", dec_bytes.size(), 2 * NBYTES);
            check_frame("b2b_first", 0, 8'h12, 8'h34);
            check_frame("b2b_second", NBYTES, 8'h56, 8'h78);
            check("b2b_gap", (dec_starts.size() > NBYTES) ? dec_starts[NBYTES] - dec_starts[0] - FRAME_CYC : -1, 1);
            check("b2b_done_pulses", done_cnt, 2);
            check("b2b_overrun", overrun, 0);
        end

        // Random traffic against the model, with a fresh reset every 1000 cycles.
        for (int c = 0; c < 3000; c++) begin
            logic dr;
            if (c % 1000 == 0) do_reset(1'b0);
            dr = data_ready;
            if ($urandom_range(0, 59) == 0) dr = ~data_ready;
            step(dr, 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
